// File: rtl/pipe_reg_chain.sv
// Stall-aware pipeline register chain of DEPTH stages with bubble insertion and flush.
// Optional debug tag path and bubble counter enabled by defining PIPE_DBG_EN.
module pipe_reg_chain #(
    parameter int unsigned      WIDTH     = 108,
    parameter int unsigned      DEPTH     = 1,
    parameter int unsigned      STALL_W   = 6,
    parameter int unsigned      BASE      = 3,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
`ifdef PIPE_DBG_EN
    input  logic [31:0]        in_dbg,
    output logic [31:0]        out_dbg,
    output logic [15:0]        bubble_cnt,
`endif
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [DEPTH-1:0]   stage_valid
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Entry k of the src_* views is the source of stage k; entry DEPTH is the last stage itself.
    logic [DEPTH:0]   src_vld;
    logic [WIDTH-1:0] src_data [DEPTH+1];
    logic             stall_unused;

    always_comb begin
        src_vld     = {vld_q, in_valid};
        src_data[0] = in_data;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            src_data[k+1] = data_q[k];
        end
        stall_unused = ^stall;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data_q[k] <= NOP_VALUE;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!stall[BASE+k]) begin
                    vld_q[k]  <= src_vld[k];
                    data_q[k] <= src_data[k];
                end else if (!stall[BASE+k+1]) begin
                    vld_q[k]  <= 1'b0;
                    data_q[k] <= NOP_VALUE;
                end
            end
        end
    end

    always_comb begin
        out_valid   = src_vld[DEPTH];
        out_data    = src_data[DEPTH];
        stage_valid = vld_q;
    end

`ifdef PIPE_DBG_EN
    logic [31:0] dbg_q   [DEPTH];
    logic [31:0] src_dbg [DEPTH+1];
    logic        last_bubble;

    always_comb begin
        src_dbg[0] = in_dbg;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            src_dbg[k+1] = dbg_q[k];
        end
        out_dbg = src_dbg[DEPTH];
        // Last stage receives an invalid entry either by explicit bubble or by shifting one in.
        last_bubble = stall[BASE+DEPTH-1] ? !stall[BASE+DEPTH] : !src_vld[DEPTH-1];
    end

    // Bubbles keep the source tag so the slot stays attributable to its instruction.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                dbg_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (!stall[BASE+k] || !stall[BASE+k+1]) begin
                    dbg_q[k] <= src_dbg[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && last_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: three chains (DEPTH 1/2/3) share one stimulus set.
module tb_pipe_reg_chain;

    localparam logic [15:0] NOP = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic [5:0]  stall;
    logic [15:0] in_data;
    logic [31:0] in_dbg;

    logic        o1_v, o2_v, o3_v;
    logic [15:0] o1_d, o2_d, o3_d;
    logic [0:0]  sv1;
    logic [1:0]  sv2;
    logic [2:0]  sv3;
    logic [31:0] dbg1, dbg2, dbg3;
    logic [15:0] cnt1, cnt2, cnt3;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(1), .STALL_W(6), .BASE(3), .NOP_VALUE(NOP)) u1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
`ifdef PIPE_DBG_EN
        .in_dbg(in_dbg), .out_dbg(dbg1), .bubble_cnt(cnt1),
`endif
        .out_valid(o1_v), .out_data(o1_d), .stage_valid(sv1));

    pipe_reg_chain #(.WIDTH(16), .DEPTH(2), .STALL_W(6), .BASE(3), .NOP_VALUE(NOP)) u2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
`ifdef PIPE_DBG_EN
        .in_dbg(in_dbg), .out_dbg(dbg2), .bubble_cnt(cnt2),
`endif
        .out_valid(o2_v), .out_data(o2_d), .stage_valid(sv2));

    pipe_reg_chain #(.WIDTH(16), .DEPTH(3), .STALL_W(6), .BASE(2), .NOP_VALUE(NOP)) u3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid), .in_data(in_data),
`ifdef PIPE_DBG_EN
        .in_dbg(in_dbg), .out_dbg(dbg3), .bubble_cnt(cnt3),
`endif
        .out_valid(o3_v), .out_data(o3_d), .stage_valid(sv3));

`ifndef PIPE_DBG_EN
    initial begin
        dbg1 = '0; dbg2 = '0; dbg3 = '0;
        cnt1 = '0; cnt2 = '0; cnt3 = '0;
    end
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0; in_dbg = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 1'b1; in_data = 16'h1111; in_dbg = 32'h55;
        tick();
        tick();
        n_cmp++; if (o1_v !== 1'b0) begin n_mis++; $display("FAIL reset_u1_valid: got %b want 0", o1_v); end
        n_cmp++; if (o1_d !== NOP) begin n_mis++; $display("FAIL reset_u1_data: got %h want %h", o1_d, NOP); end
        n_cmp++; if (sv2 !== 2'b00) begin n_mis++; $display("FAIL reset_u2_stage_valid: got %b want 00", sv2); end
        n_cmp++; if (sv3 !== 3'b000) begin n_mis++; $display("FAIL reset_u3_stage_valid: got %b want 000", sv3); end
        n_cmp++; if (o3_d !== NOP) begin n_mis++; $display("FAIL reset_u3_data: got %h want %h", o3_d, NOP); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (dbg1 !== 32'h0) begin n_mis++; $display("FAIL reset_u1_dbg: got %h want 0", dbg1); end
        n_cmp++; if (cnt1 !== 16'h0) begin n_mis++; $display("FAIL reset_u1_cnt: got %h want 0", cnt1); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_shift;
        do_reset();
        in_valid = 1'b1; in_data = 16'hA0A0;
        tick();
        n_cmp++; if (o1_d !== 16'hA0A0 || o1_v !== 1'b1) begin n_mis++; $display("FAIL shift_u1_A: got %b/%h want 1/a0a0", o1_v, o1_d); end
        n_cmp++; if (o2_v !== 1'b0) begin n_mis++; $display("FAIL shift_u2_early: got valid %b want 0", o2_v); end
        in_data = 16'hB0B0;
        tick();
        n_cmp++; if (o1_d !== 16'hB0B0) begin n_mis++; $display("FAIL shift_u1_B: got %h want b0b0", o1_d); end
        n_cmp++; if (o2_d !== 16'hA0A0 || o2_v !== 1'b1) begin n_mis++; $display("FAIL shift_u2_A: got %b/%h want 1/a0a0", o2_v, o2_d); end
        in_data = 16'hC0C0;
        tick();
        n_cmp++; if (o2_d !== 16'hB0B0 || o2_v !== 1'b1) begin n_mis++; $display("FAIL shift_u2_B: got %b/%h want 1/b0b0", o2_v, o2_d); end
        n_cmp++; if (o3_d !== 16'hA0A0 || o3_v !== 1'b1) begin n_mis++; $display("FAIL shift_u3_A: got %b/%h want 1/a0a0", o3_v, o3_d); end
        n_cmp++; if (sv3 !== 3'b111) begin n_mis++; $display("FAIL shift_u3_stage_valid: got %b want 111", sv3); end
        in_valid = 1'b0; in_data = 16'h0055;
        tick();
        n_cmp++; if (o1_v !== 1'b0 || o1_d !== 16'h0055) begin n_mis++; $display("FAIL shift_u1_invalid: got %b/%h want 0/0055", o1_v, o1_d); end
        n_cmp++; if (o2_d !== 16'hC0C0 || o2_v !== 1'b1) begin n_mis++; $display("FAIL shift_u2_C: got %b/%h want 1/c0c0", o2_v, o2_d); end
        n_cmp++; if (o3_d !== 16'hB0B0) begin n_mis++; $display("FAIL shift_u3_B: got %h want b0b0", o3_d); end
        tick();
        n_cmp++; if (o3_d !== 16'hC0C0 || o3_v !== 1'b1) begin n_mis++; $display("FAIL shift_u3_C: got %b/%h want 1/c0c0", o3_v, o3_d); end
        n_cmp++; if (o2_v !== 1'b0 || o2_d !== 16'h0055) begin n_mis++; $display("FAIL shift_u2_invalid: got %b/%h want 0/0055", o2_v, o2_d); end
    endtask

    task automatic test_bubble;
        do_reset();
        in_valid = 1'b1; in_data = 16'hD1D1; in_dbg = 32'h1111;
        tick();
        stall = 6'b001000; in_data = 16'hD2D2; in_dbg = 32'h1234;
        tick();
        n_cmp++; if (o1_v !== 1'b0) begin n_mis++; $display("FAIL bubble_u1_valid: got %b want 0", o1_v); end
        n_cmp++; if (o1_d !== NOP) begin n_mis++; $display("FAIL bubble_u1_data: got %h want %h", o1_d, NOP); end
        n_cmp++; if (o2_d !== 16'hD1D1 || o2_v !== 1'b1) begin n_mis++; $display("FAIL bubble_u2_shift: got %b/%h want 1/d1d1", o2_v, o2_d); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (dbg1 !== 32'h1234) begin n_mis++; $display("FAIL bubble_u1_dbg: got %h want 1234", dbg1); end
        n_cmp++; if (cnt1 !== 16'd1) begin n_mis++; $display("FAIL bubble_u1_cnt: got %0d want 1", cnt1); end
`endif
        stall = '0;
        tick();
        n_cmp++; if (o1_d !== 16'hD2D2 || o1_v !== 1'b1) begin n_mis++; $display("FAIL bubble_u1_resume: got %b/%h want 1/d2d2", o1_v, o1_d); end
        n_cmp++; if (o2_v !== 1'b0 || o2_d !== NOP) begin n_mis++; $display("FAIL bubble_u2_arrive: got %b/%h want 0/%h", o2_v, o2_d, NOP); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (dbg2 !== 32'h1234) begin n_mis++; $display("FAIL bubble_u2_dbg: got %h want 1234", dbg2); end
        n_cmp++; if (cnt1 !== 16'd1) begin n_mis++; $display("FAIL bubble_u1_cnt_after: got %0d want 1", cnt1); end
`endif
    endtask

    task automatic test_hold;
        do_reset();
        in_valid = 1'b1; in_data = 16'h0D0D; in_dbg = 32'h00D0;
        tick();
        stall = 6'b011000; in_data = 16'hEEEE; in_dbg = 32'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (o1_d !== 16'h0D0D || o1_v !== 1'b1) begin n_mis++; $display("FAIL hold_u1_cycle%0d: got %b/%h want 1/0d0d", i, o1_v, o1_d); end
`ifdef PIPE_DBG_EN
            n_cmp++; if (dbg1 !== 32'h00D0 || cnt1 !== 16'd0) begin n_mis++; $display("FAIL hold_u1_dbg_cnt%0d: got %h/%0d want d0/0", i, dbg1, cnt1); end
`endif
        end
        stall = '0;
        tick();
        n_cmp++; if (o1_d !== 16'hEEEE || o1_v !== 1'b1) begin n_mis++; $display("FAIL hold_u1_release: got %b/%h want 1/eeee", o1_v, o1_d); end
    endtask

    task automatic test_flush;
        do_reset();
        in_valid = 1'b1; in_dbg = 32'hF1F1;
        in_data = 16'hF001; tick();
        in_data = 16'hF002; tick();
        in_data = 16'hF003; tick();
        n_cmp++; if (sv3 !== 3'b111 || o3_d !== 16'hF001) begin n_mis++; $display("FAIL flush_u3_filled: got %b/%h want 111/f001", sv3, o3_d); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (cnt3 !== 16'd2) begin n_mis++; $display("FAIL flush_u3_cnt_before: got %0d want 2", cnt3); end
`endif
        flush = 1'b1; stall = 6'b111000;
        tick();
        n_cmp++; if (sv3 !== 3'b000) begin n_mis++; $display("FAIL flush_u3_stage_valid: got %b want 000", sv3); end
        n_cmp++; if (o3_d !== NOP || o3_v !== 1'b0) begin n_mis++; $display("FAIL flush_u3_out: got %b/%h want 0/%h", o3_v, o3_d, NOP); end
        n_cmp++; if (o1_d !== NOP || o1_v !== 1'b0) begin n_mis++; $display("FAIL flush_u1_out: got %b/%h want 0/%h", o1_v, o1_d, NOP); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (dbg3 !== 32'h0) begin n_mis++; $display("FAIL flush_u3_dbg: got %h want 0", dbg3); end
        n_cmp++; if (cnt3 !== 16'd2) begin n_mis++; $display("FAIL flush_u3_cnt_after: got %0d want 2", cnt3); end
`endif
        flush = 1'b0; stall = '0; in_data = 16'h6060;
        tick();
        n_cmp++; if (sv3 !== 3'b001) begin n_mis++; $display("FAIL flush_u3_refill: got %b want 001", sv3); end
    endtask

    task automatic test_reset_priority;
        do_reset();
        in_valid = 1'b1; in_dbg = 32'hABCD;
        in_data = 16'h1A1A; tick();
        in_data = 16'h2B2B; tick();
        stall = 6'b111000; in_data = 16'h3C3C;
        tick();
        n_cmp++; if (o2_d !== 16'h1A1A || o2_v !== 1'b1) begin n_mis++; $display("FAIL rstpri_u2_held: got %b/%h want 1/1a1a", o2_v, o2_d); end
        rst = 1'b1; flush = 1'b1;
        tick();
        n_cmp++; if (o2_v !== 1'b0 || o2_d !== NOP) begin n_mis++; $display("FAIL rstpri_u2_out: got %b/%h want 0/%h", o2_v, o2_d, NOP); end
        n_cmp++; if (sv2 !== 2'b00) begin n_mis++; $display("FAIL rstpri_u2_stage_valid: got %b want 00", sv2); end
`ifdef PIPE_DBG_EN
        n_cmp++; if (dbg2 !== 32'h0) begin n_mis++; $display("FAIL rstpri_u2_dbg: got %h want 0", dbg2); end
        n_cmp++; if (cnt2 !== 16'd0) begin n_mis++; $display("FAIL rstpri_u2_cnt: got %0d want 0", cnt2); end
`endif
        rst = 1'b0; flush = 1'b0; stall = 6'b011000; in_data = 16'h4D4D;
        tick();
        n_cmp++; if (o1_v !== 1'b0 || o1_d !== NOP) begin n_mis++; $display("FAIL rstpri_u1_hold_after: got %b/%h want 0/%h", o1_v, o1_d, NOP); end
        stall = '0;
        tick();
        n_cmp++; if (o1_v !== 1'b1 || o1_d !== 16'h4D4D) begin n_mis++; $display("FAIL rstpri_u1_resume: got %b/%h want 1/4d4d", o1_v, o1_d); end
    endtask

`ifdef PIPE_DBG_EN
    task automatic test_saturate;
        do_reset();
        in_valid = 1'b0; stall = '0;
        repeat (100) tick();
        n_cmp++; if (cnt1 !== 16'd100) begin n_mis++; $display("FAIL sat_cnt_100: got %0d want 100", cnt1); end
        repeat (65435) tick();
        n_cmp++; if (cnt1 !== 16'hFFFF) begin n_mis++; $display("FAIL sat_cnt_max: got %h want ffff", cnt1); end
        repeat (5) tick();
        n_cmp++; if (cnt1 !== 16'hFFFF) begin n_mis++; $display("FAIL sat_cnt_stuck: got %h want ffff", cnt1); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (cnt1 !== 16'hFFFF) begin n_mis++; $display("FAIL sat_cnt_flush: got %h want ffff", cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_shift();
        test_bubble();
        test_hold();
        test_flush();
        test_reset_priority();
`ifdef PIPE_DBG_EN
        test_saturate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
